// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch/decode entry type and default widths
package cpu_fetch_pkg;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_queue_ram.sv
// inst_queue_ram: entry storage, synchronous write and asynchronous read
module inst_queue_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/inst_queue.sv
// inst_queue: FWFT fetch-to-decode queue of {pc, inst} with flush and occupancy status
module inst_queue
  import cpu_fetch_pkg::*;
#(
  parameter int INST_WIDTH         = INST_W,
  parameter int PC_WIDTH           = PC_W,
  parameter int BUFFER_DEPTH       = 8,
  parameter int ALMOST_FULL_THRESH = BUFFER_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INST_WIDTH-1:0]         in_inst,
  input  logic [PC_WIDTH-1:0]           in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INST_WIDTH-1:0]         out_inst,
  output logic [PC_WIDTH-1:0]           out_pc,
  output logic [$clog2(BUFFER_DEPTH):0] count,
  output logic                          almost_full,
  output logic                          is_empty,
  output logic                          is_full
);
  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(ALMOST_FULL_THRESH);
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        w_push, w_pop;
  logic [PC_WIDTH+INST_WIDTH-1:0] w_rdata;
  assign count       = r_wr_ptr - r_rd_ptr;
  assign is_empty    = r_wr_ptr == r_rd_ptr;
  assign is_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign almost_full = count >= AF_TH;
  assign in_ready    = !is_full;
  assign out_valid   = !is_empty;
  // flush wins over both handshakes, so neither pointer nor storage sees them
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  inst_queue_ram #(
    .WIDTH(PC_WIDTH + INST_WIDTH),
    .DEPTH(BUFFER_DEPTH)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_push),
    .i_waddr(r_wr_ptr[AW-1:0]),
    .i_wdata({in_pc, in_inst}),
    .i_raddr(r_rd_ptr[AW-1:0]),
    .o_rdata(w_rdata)
  );
  assign {out_pc, out_inst} = w_rdata;
endmodule
